// File: rtl/switch_entry_pkg.sv
// Shared types, default sizing and one-hot helpers for the switch entry path.
package switch_entry_pkg;

    localparam int N_SW_DEF          = 8;
    localparam int IDX_W_DEF         = 4;
    localparam int STABLE_CYCLES_DEF = 4;
    localparam int DEPTH_DEF         = 4;

    typedef enum logic [1:0] {
        ST_RELEASE,
        ST_IDLE,
        ST_SETTLE,
        ST_EVAL
    } state_e;

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    function automatic logic [31:0] onehot_idx(input logic [31:0] v);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = 32'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/switch_entry_fifo.sv
// DEPTH x IDX_W synchronous FIFO; a push into a full FIFO succeeds only
// when a pop happens in the same cycle, otherwise it is reported as dropped.
module switch_entry_fifo
    import switch_entry_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [IDX_W-1:0]         data_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [IDX_W-1:0]         head_o,
    output logic                     drop_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign pop   = ready_i && !empty;
    assign wr_en = push_i && (!full || pop);

    assign drop_o  = push_i && full && !pop;
    assign valid_o = !empty;
    assign head_o  = empty ? '0 : mem_q[rd_q];
    assign count_o = cnt_q;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (pop)   rd_d = rd_q + 1'b1;
        if (wr_en) wr_d = wr_q + 1'b1;
        if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!wr_en && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/switch_entry_ctrl.sv
// Synchronise, debounce and one-hot validate a switch vector, queueing indices.
// Optional SWITCH_ENTRY_ERRCNT_EN adds a saturating err_count output.
module switch_entry_ctrl
    import switch_entry_pkg::*;
#(
    parameter int N_SW          = N_SW_DEF,
    parameter int IDX_W         = IDX_W_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int DEPTH         = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SW-1:0]        sw,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   bad_pulse,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef SWITCH_ENTRY_ERRCNT_EN
    ,
    output logic [7:0]             err_count
`endif
);

    localparam int SC_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] LAST = SC_W'(STABLE_CYCLES - 1);

    logic [N_SW-1:0]  sync1_q;
    logic [N_SW-1:0]  sw_s_q;
    state_e           state_q, state_d;
    logic [SC_W-1:0]  cnt_q, cnt_d;
    logic [N_SW-1:0]  cap_q, cap_d;
    logic             overflow_q;
    logic             cap_ok;
    logic             push;
    logic             drop;
    logic [IDX_W-1:0] push_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sw_s_q  <= '0;
        end else begin
            sync1_q <= sw;
            sw_s_q  <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        unique case (state_q)
            ST_RELEASE: begin
                if (sw_s_q != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (sw_s_q != '0) begin
                    state_d = ST_SETTLE;
                    cap_d   = sw_s_q;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (sw_s_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (sw_s_q != cap_q) begin
                    cap_d = sw_s_q;
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = ST_EVAL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_EVAL: begin
                state_d = ST_RELEASE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_RELEASE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RELEASE;
            cnt_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

    assign cap_ok    = is_onehot(32'(cap_q));
    assign push      = (state_q == ST_EVAL) && cap_ok;
    assign bad_pulse = (state_q == ST_EVAL) && !cap_ok;
    assign push_idx  = IDX_W'(onehot_idx(32'(cap_q)));

    switch_entry_fifo #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_idx),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .head_o  (out_idx),
        .drop_o  (drop),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst)       overflow_q <= 1'b0;
        else if (drop) overflow_q <= 1'b1;
    end

    assign overflow = overflow_q;

`ifdef SWITCH_ENTRY_ERRCNT_EN
    logic [7:0] err_q;

    // bad_pulse and drop both come from the single EVAL cycle, never together
    always_ff @(posedge clk) begin
        if (rst)                                      err_q <= '0;
        else if ((bad_pulse || drop) && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_switch_entry_ctrl.sv
// Bench for switch_entry_ctrl: directed scenarios plus randomised presses
// checked against a queue model of accepted selections.
module tb_switch_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw = '0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [3:0] out_idx;
    logic       bad_pulse;
    logic       overflow;
    logic [2:0] fifo_count;
`ifdef SWITCH_ENTRY_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int tests = 0;
    int fails = 0;
    int bad_seen = 0;

    switch_entry_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .bad_pulse  (bad_pulse),
        .overflow   (overflow),
        .fifo_count (fifo_count)
`ifdef SWITCH_ENTRY_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bad_pulse === 1'b1) bad_seen++;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sw = '0;
        out_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(8);
    endtask

    task automatic press(input logic [7:0] v, input int hold, input int rel);
        sw = v;
        tick(hold);
        sw = '0;
        tick(rel);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw = 8'hA5;
        out_ready = 1'b1;
        tick(3);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b expected 0", out_valid); end
        tests++; if (out_idx !== 4'd0) begin fails++; $display("FAIL rst_idx: got %0d expected 0", out_idx); end
        tests++; if (bad_pulse !== 1'b0) begin fails++; $display("FAIL rst_bad: got %0b expected 0", bad_pulse); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_ovf: got %0b expected 0", overflow); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
`ifdef SWITCH_ENTRY_ERRCNT_EN
        tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL rst_err: got %0d expected 0", err_count); end
`endif
        rst = 1'b0;
        sw = '0;
        out_ready = 1'b0;
        tick(8);
    endtask

    task automatic test_latency();
        int lat;
        do_reset();
        lat = -1;
        sw = 8'h04;
        tick(1);
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (lat < 0 && out_valid === 1'b1) lat = i;
        end
        tests++; if (lat != 7) begin fails++; $display("FAIL lat_cycles: got %0d expected 7", lat); end
        tests++; if (out_idx !== 4'd2) begin fails++; $display("FAIL lat_idx: got %0d expected 2", out_idx); end
        tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL lat_count: got %0d expected 1", fifo_count); end
        sw = '0;
        tick(8);
    endtask

    task automatic test_bounce();
        int bs;
        do_reset();
        bs = bad_seen;
        for (int i = 0; i < 5; i++) begin
            sw = (i % 2 == 0) ? 8'h10 : 8'h00;
            tick(1);
        end
        sw = 8'h10;
        tick(12);
        tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL bnc_count: got %0d expected 1", fifo_count); end
        tests++; if (out_idx !== 4'd4) begin fails++; $display("FAIL bnc_idx: got %0d expected 4", out_idx); end
        tick(20);
        tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL bnc_held: got %0d expected 1", fifo_count); end
        tests++; if (bad_seen != bs) begin fails++; $display("FAIL bnc_bad: got %0d expected 0", bad_seen - bs); end
        sw = '0;
        tick(8);
        press(8'h10, 10, 8);
        tests++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL bnc_repress: got %0d expected 2", fifo_count); end
    endtask

    task automatic test_bad();
        int bs;
        do_reset();
        bs = bad_seen;
        press(8'h06, 10, 8);
        tests++; if (bad_seen - bs != 1) begin fails++; $display("FAIL bad_pulses: got %0d expected 1", bad_seen - bs); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL bad_count: got %0d expected 0", fifo_count); end
`ifdef SWITCH_ENTRY_ERRCNT_EN
        tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL bad_err: got %0d expected 1", err_count); end
`endif
    endtask

    task automatic test_overflow();
        int prs[5] = '{0, 1, 2, 3, 7};
        do_reset();
        for (int i = 0; i < 5; i++) press(8'h01 << prs[i], 10, 8);
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
        tests++; if (out_idx !== 4'd0) begin fails++; $display("FAIL ovf_head: got %0d expected 0", out_idx); end
`ifdef SWITCH_ENTRY_ERRCNT_EN
        tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL ovf_err: got %0d expected 1", err_count); end
`endif
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tests++;
            if (out_valid !== 1'b1 || out_idx !== 4'(j)) begin
                fails++;
                $display("FAIL ovf_pop%0d: got valid=%0b idx=%0d expected valid=1 idx=%0d", j, out_valid, out_idx, j);
            end
            tick(1);
        end
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovf_drained: got %0b expected 0", out_valid); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
    endtask

    task automatic test_full_pop();
        int expd[4] = '{1, 2, 3, 5};
        do_reset();
        for (int i = 0; i < 4; i++) press(8'h01 << i, 10, 8);
        sw = 8'h20;
        tick(7);
        out_ready = 1'b1;
        tests++; if (out_idx !== 4'd0) begin fails++; $display("FAIL fp_head: got %0d expected 0", out_idx); end
        tick(1);
        out_ready = 1'b0;
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fp_ovf: got %0b expected 0", overflow); end
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL fp_count: got %0d expected 4", fifo_count); end
        tick(4);
        sw = '0;
        tick(8);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tests++;
            if (out_valid !== 1'b1 || out_idx !== 4'(expd[j])) begin
                fails++;
                $display("FAIL fp_pop%0d: got valid=%0b idx=%0d expected valid=1 idx=%0d", j, out_valid, out_idx, expd[j]);
            end
            tick(1);
        end
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fp_drained: got %0b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int bs;
        do_reset();
        press(8'h02, 10, 8);
        press(8'h40, 10, 8);
        tests++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL rm_pre: got %0d expected 2", fifo_count); end
        sw = 8'h08;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL rm_count: got %0d expected 0", fifo_count); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rm_valid: got %0b expected 0", out_valid); end
        tests++; if (out_idx !== 4'd0) begin fails++; $display("FAIL rm_idx: got %0d expected 0", out_idx); end
        tests++; if (bad_pulse !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL rm_flags: got bad=%0b ovf=%0b expected 0 0", bad_pulse, overflow); end
        bs = bad_seen;
        tick(20);
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL rm_held: got %0d expected 0", fifo_count); end
        tests++; if (bad_seen != bs) begin fails++; $display("FAIL rm_bad: got %0d expected 0", bad_seen - bs); end
        sw = '0;
        tick(8);
        press(8'h08, 10, 8);
        tests++; if (fifo_count !== 3'd1 || out_idx !== 4'd3) begin fails++; $display("FAIL rm_after: got count=%0d idx=%0d expected 1 3", fifo_count, out_idx); end
    endtask

    task automatic test_random();
        int q[$];
        int bs;
        int nbad;
        int tot_bad;
        int guard;
        int n;
        int nb;
        int tmp;
        logic [7:0] v;
        logic [7:0] bv;
        logic [7:0] prev;
        do_reset();
        tot_bad = 0;
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 4);
            bs = bad_seen;
            nbad = 0;
            for (int p = 0; p < n; p++) begin
                if ($urandom_range(0, 1) == 1) v = 8'h01 << $urandom_range(0, 7);
                else v = 8'($urandom_range(1, 255));
                nb = $urandom_range(0, 4);
                prev = '0;
                for (int b = 0; b < nb; b++) begin
                    do bv = 8'($urandom); while (bv == prev || bv == v);
                    sw = bv;
                    tick(1);
                    prev = bv;
                end
                press(v, $urandom_range(8, 14), $urandom_range(8, 12));
                if ($countones(v) == 1) begin
                    tmp = 0;
                    for (int k = 0; k < 8; k++) if (v[k]) tmp = k;
                    q.push_back(tmp);
                end else begin
                    nbad++;
                end
            end
            tot_bad += nbad;
            tests++; if (bad_seen - bs != nbad) begin fails++; $display("FAIL rnd_bad r%0d: got %0d expected %0d", r, bad_seen - bs, nbad); end
            guard = 0;
            while (q.size() > 0 && guard < 100) begin
                tests++;
                if (fifo_count !== 3'(q.size())) begin fails++; $display("FAIL rnd_count r%0d: got %0d expected %0d", r, fifo_count, q.size()); end
                out_ready = ($urandom_range(0, 1) == 1);
                if (out_valid === 1'b1 && out_ready) begin
                    tmp = q.pop_front();
                    tests++;
                    if (out_idx !== 4'(tmp)) begin fails++; $display("FAIL rnd_idx r%0d: got %0d expected %0d", r, out_idx, tmp); end
                end
                tick(1);
                guard++;
            end
            out_ready = 1'b0;
            tests++; if (q.size() != 0) begin fails++; $display("FAIL rnd_timeout r%0d: got %0d entries left expected 0", r, q.size()); q.delete(); end
            tests++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin fails++; $display("FAIL rnd_empty r%0d: got valid=%0b count=%0d expected 0 0", r, out_valid, fifo_count); end
        end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rnd_ovf: got %0b expected 0", overflow); end
`ifdef SWITCH_ENTRY_ERRCNT_EN
        tests++; if (err_count !== 8'(tot_bad)) begin fails++; $display("FAIL rnd_err: got %0d expected %0d", err_count, tot_bad); end
`endif
    endtask

    initial begin
        test_reset();
        test_latency();
        test_bounce();
        test_bad();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
